// File: rtl/uart_rx_wb.sv
// -----------------------------------------------------------------------------
// uart_rx_wb
//
// Receives 8N1 serial frames on uart_rx. Each byte with a valid stop bit is
// issued as one Wishbone pipelined write of wb_dat_o. wb_dat_o doubles as the
// one-byte holding register: it is busy from byte load until the write is
// acknowledged.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   uart_rx      serial input, idle high, asynchronous to clk_i
//   wb_cyc_o     Wishbone cycle, high from request until acknowledge
//   wb_stb_o     Wishbone strobe, high until the slave accepts the write
//   wb_dat_o     received byte
//   wb_stall_i   slave stall
//   wb_ack_i     slave acknowledge
//   frame_err_o  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun_o    one-cycle pulse: byte completed while the holding register
//                was busy, new byte dropped
//
// Handshake: wb_stb_o acts as valid and !wb_stall_i as ready. A write is
// accepted on any cycle with wb_stb_o && !wb_stall_i; wb_dat_o holds its
// value while wb_stb_o is high. wb_cyc_o stays high until a cycle with
// wb_ack_i, which may coincide with the accepting cycle. wb_ack_i is ignored
// while no write is outstanding.
// -----------------------------------------------------------------------------
module uart_rx_wb #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       uart_rx,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic [7:0] wb_dat_o,
    input  logic       wb_stall_i,
    input  logic       wb_ack_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_ACK} wb_state_e;

    // Both FSM states in one observable struct.
    typedef struct packed {
        rx_state_e rx;
        wb_state_e wb;
    } fsm_dbg_t;

    rx_state_e     rx_state, rx_next;
    wb_state_e     wb_state, wb_next;
    fsm_dbg_t      fsm_dbg;

    logic          rx_meta, rx_s;
    logic [1:0]    warm;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic          cnt_clear, bit_tick, byte_done, stop_bad;

    assign fsm_dbg.rx = rx_state;
    assign fsm_dbg.wb = wb_state;

    // Two-flop synchroniser, idle (high) at reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // The synchroniser's reset value is not a real observation of the line.
    // Start detection is armed only once rx_s has shown the pin high, so a
    // frame already in progress at reset release is hunted from its next
    // falling edge instead of its middle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & rx_s);
        end
    end

    // ---------------- receive FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (armed && !rx_s) rx_next = RX_START;
            RX_START: if (cnt == HALF) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt == LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cnt == LAST) rx_next = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_s) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        bit_tick  = (fsm_dbg.rx == RX_DATA) && (cnt == LAST);
        byte_done = (fsm_dbg.rx == RX_STOP) && (cnt == LAST) && rx_s;
        stop_bad  = (fsm_dbg.rx == RX_STOP) && (cnt == LAST) && !rx_s;
        // The counter restarts at every sample point so each following
        // sample lands a full bit period later.
        cnt_clear = (fsm_dbg.rx == RX_IDLE) || (fsm_dbg.rx == RX_BREAK) ||
                    ((fsm_dbg.rx == RX_START) && (cnt == HALF)) ||
                    (((fsm_dbg.rx == RX_DATA) || (fsm_dbg.rx == RX_STOP)) && (cnt == LAST));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            cnt <= cnt_clear ? '0 : cnt + CW'(1);
            if (rx_state != RX_DATA) bit_idx <= 3'd0;
            else if (bit_tick)       bit_idx <= bit_idx + 3'd1;
            if (bit_tick) shift <= {rx_s, shift[7:1]};
        end
    end

    // ---------------- Wishbone master FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wb_state <= W_IDLE;
        else         wb_state <= wb_next;
    end

    always_comb begin
        wb_next = wb_state;
        case (wb_state)
            W_IDLE:  if (byte_done) wb_next = W_REQ;
            W_REQ:   if (!wb_stall_i) wb_next = wb_ack_i ? W_IDLE : W_ACK;
            W_ACK:   if (wb_ack_i) wb_next = W_IDLE;
            default: wb_next = W_IDLE;
        endcase
    end

    always_comb begin
        wb_cyc_o = (fsm_dbg.wb != W_IDLE);
        wb_stb_o = (fsm_dbg.wb == W_REQ);
    end

    // Holding register and error pulses. A byte completing on the edge where
    // the write finishes still sees a busy register and is counted as overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_dat_o    <= 8'h00;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_bad;
            overrun_o   <= byte_done && (wb_state != W_IDLE);
            if (byte_done && wb_state == W_IDLE) wb_dat_o <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_wb.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_wb
//
// Directed steps plus a randomized frame sequence for uart_rx_wb with
// CLKS_PER_BIT = 16. A serial driver task produces frames, a Wishbone slave
// process stalls/acks according to per-step settings and records every
// accepted byte, and a monitor records pulse and strobe timing. Expected
// values come from frame-level rules: a frame with a high stop bit delivers
// its byte unless a write is still outstanding; a low stop bit gives one
// frame_err pulse; results appear 3 + CPB/2 + 9*CPB + 1 clocks after the
// start-bit falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_wb;

    localparam int CPB = 16;
    localparam int LAT = 3 + CPB / 2 + 9 * CPB + 1;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       uart_rx = 1'b1;
    logic       wb_cyc_o, wb_stb_o;
    logic [7:0] wb_dat_o;
    logic       wb_stall_i, wb_ack_i;
    logic       frame_err_o, overrun_o;

    uart_rx_wb #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .uart_rx     (uart_rx),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_o    (wb_dat_o),
        .wb_stall_i  (wb_stall_i),
        .wb_ack_i    (wb_ack_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk_i = ~clk_i;

    int cyc_cnt = 0;
    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int start_q[$], stb_rise_q[$], fe_rise_q[$], ov_rise_q[$];
    int stb_len_q[$], cyc_len_q[$];
    int fe_cnt = 0, ov_cnt = 0, dat_unstable = 0, cyc_fall_cyc = 0, ack_cyc = 0;

    int   stall_cfg = 0, ack_delay = 0;
    logic ack_hold = 1'b0;

    // Baselines so each step looks only at what it produced.
    int got_b, start_b, rise_b, fe_rise_b, ov_rise_b, len_b, clen_b, fe_b, ov_b, unst_b;

    task automatic mark();
        got_b     = got_q.size();
        start_b   = start_q.size();
        rise_b    = stb_rise_q.size();
        fe_rise_b = fe_rise_q.size();
        ov_rise_b = ov_rise_q.size();
        len_b     = stb_len_q.size();
        clen_b    = cyc_len_q.size();
        fe_b      = fe_cnt;
        ov_b      = ov_cnt;
        unst_b    = dat_unstable;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [31:0] got_at(input int i);
        if (got_b + i < got_q.size()) return 32'(got_q[got_b + i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // ---------------- serial driver ----------------
    // Start bit, 8 data bits LSB first, stop bit; line left at the stop level.
    task automatic send(input logic [7:0] d, input logic stop);
        @(negedge clk_i);
        uart_rx = 1'b0;
        start_q.push_back(cyc_cnt);
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk_i);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk_i);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    // ---------------- Wishbone slave ----------------
    int stall_left = 0, ack_left = 0;
    initial begin
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        forever begin
            @(negedge clk_i);
            wb_stall_i = 1'b0;
            wb_ack_i   = 1'b0;
            if (!rst_ni) begin
                stall_left = stall_cfg;
            end else if (wb_stb_o) begin
                if (stall_left > 0) begin
                    wb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    got_q.push_back(wb_dat_o);
                    if (!ack_hold && ack_delay == 0) begin
                        wb_ack_i = 1'b1;
                        ack_cyc  = cyc_cnt;
                    end else begin
                        ack_left = ack_delay;
                    end
                end
            end else if (wb_cyc_o) begin
                if (!ack_hold) begin
                    if (ack_left > 1) ack_left--;
                    else begin
                        wb_ack_i = 1'b1;
                        ack_cyc  = cyc_cnt;
                    end
                end
            end else begin
                stall_left = stall_cfg;
            end
        end
    end

    // ---------------- monitor ----------------
    logic       stb_prev = 1'b0, cyc_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    logic [7:0] dat_prev = 8'h00;
    int         stb_run = 0, cyc_run = 0;

    always @(negedge clk_i) begin
        stb_prev <= wb_stb_o;
        cyc_prev <= wb_cyc_o;
        fe_prev  <= frame_err_o;
        ov_prev  <= overrun_o;
        dat_prev <= wb_dat_o;
        stb_run  <= wb_stb_o ? stb_run + 1 : 0;
        cyc_run  <= wb_cyc_o ? cyc_run + 1 : 0;
        if (wb_stb_o && !stb_prev) stb_rise_q.push_back(cyc_cnt);
        if (stb_prev && !wb_stb_o) stb_len_q.push_back(stb_run);
        if (cyc_prev && !wb_cyc_o) begin
            cyc_len_q.push_back(cyc_run);
            cyc_fall_cyc <= cyc_cnt;
        end
        if (wb_stb_o && stb_prev && wb_dat_o !== dat_prev) dat_unstable <= dat_unstable + 1;
        if (frame_err_o) fe_cnt <= fe_cnt + 1;
        if (overrun_o) ov_cnt <= ov_cnt + 1;
        if (frame_err_o && !fe_prev) fe_rise_q.push_back(cyc_cnt);
        if (overrun_o && !ov_prev) ov_rise_q.push_back(cyc_cnt);
    end

    // ---------------- directed + random steps ----------------
    int         exp_fe;
    logic [7:0] rd;
    logic       rstop;

    initial begin
        // Reset state
        settle(3);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_dat", wb_dat_o, 8'h00);
        check("rst_fe", frame_err_o, 0);
        check("rst_ov", overrun_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        settle(2 * CPB);

        // Back-to-back 0x55, 0xA3, no stall, ack at acceptance
        mark();
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        settle(20);
        check("b2b_count", got_q.size() - got_b, 2);
        check("b2b_d0", got_at(0), 8'h55);
        check("b2b_d1", got_at(1), 8'hA3);
        check("b2b_lat0", qget(stb_rise_q, rise_b) - qget(start_q, start_b), LAT);
        check("b2b_lat1", qget(stb_rise_q, rise_b + 1) - qget(start_q, start_b + 1), LAT);
        check("b2b_stb_len", qget(stb_len_q, len_b), 1);
        check("b2b_cyc_len", qget(cyc_len_q, clen_b), 1);
        check("b2b_fe", fe_cnt - fe_b, 0);
        check("b2b_ov", ov_cnt - ov_b, 0);

        // 0x3C with 5 stall cycles, ack 2 cycles after acceptance
        stall_cfg = 5;
        ack_delay = 2;
        settle(2);
        mark();
        send(8'h3C, 1'b1);
        settle(20);
        check("stall_count", got_q.size() - got_b, 1);
        check("stall_data", got_at(0), 8'h3C);
        check("stall_stb_len", qget(stb_len_q, len_b), 6);
        check("stall_cyc_len", qget(cyc_len_q, clen_b), 8);
        check("stall_dat_stable", dat_unstable - unst_b, 0);
        check("stall_cyc_drop", cyc_fall_cyc - ack_cyc, 1);
        check("stall_lat", qget(stb_rise_q, rise_b) - qget(start_q, start_b), LAT);

        // Bad stop on 0x81, line held low 40 bit times, then 0x12
        stall_cfg = 0;
        ack_delay = 0;
        settle(2);
        mark();
        send(8'h81, 1'b0);
        repeat (40 * CPB) @(negedge clk_i);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk_i);
        send(8'h12, 1'b1);
        settle(20);
        check("brk_fe_cycles", fe_cnt - fe_b, 1);
        check("brk_fe_lat", qget(fe_rise_q, fe_rise_b) - qget(start_q, start_b), LAT);
        check("brk_count", got_q.size() - got_b, 1);
        check("brk_data", got_at(0), 8'h12);
        check("brk_ov", ov_cnt - ov_b, 0);

        // Three-clock low glitch on an idle line
        mark();
        @(negedge clk_i);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk_i);
        uart_rx = 1'b1;
        settle(3 * CPB);
        check("glitch_count", got_q.size() - got_b, 0);
        check("glitch_stb", stb_rise_q.size() - rise_b, 0);
        check("glitch_fe", fe_cnt - fe_b, 0);
        check("glitch_cyc", wb_cyc_o, 0);

        // 0x11 then 0x22 with ack withheld: overrun on the second byte
        ack_hold = 1'b1;
        mark();
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        settle(5);
        check("ovr_pulse_cycles", ov_cnt - ov_b, 1);
        check("ovr_lat", qget(ov_rise_q, ov_rise_b) - qget(start_q, start_b + 1), LAT);
        check("ovr_dat_held", wb_dat_o, 8'h11);
        check("ovr_cyc_held", wb_cyc_o, 1);
        ack_hold = 1'b0;
        settle(5);
        check("ovr_cyc_after_ack", wb_cyc_o, 0);
        check("ovr_count", got_q.size() - got_b, 1);
        check("ovr_data", got_at(0), 8'h11);
        check("ovr_stb_rises", stb_rise_q.size() - rise_b, 1);
        check("ovr_fe", fe_cnt - fe_b, 0);

        // Reset in the middle of data bit 4 of 0xF0, then 0x0F
        mark();
        @(negedge clk_i);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'b0;
            repeat (CPB) @(negedge clk_i);
        end
        uart_rx = 1'b1;
        repeat (CPB / 2) @(negedge clk_i);
        rst_ni = 1'b0;
        settle(2);
        check("mid_rst_cyc", wb_cyc_o, 0);
        check("mid_rst_stb", wb_stb_o, 0);
        check("mid_rst_dat", wb_dat_o, 8'h00);
        check("mid_rst_fe", frame_err_o, 0);
        check("mid_rst_ov", overrun_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (6 * CPB) @(negedge clk_i);
        send(8'h0F, 1'b1);
        settle(20);
        check("rst_count", got_q.size() - got_b, 1);
        check("rst_data", got_at(0), 8'h0F);
        check("rst_fe_none", fe_cnt - fe_b, 0);
        check("rst_ov_none", ov_cnt - ov_b, 0);

        // Randomized frames against the frame-level model
        mark();
        exp_fe = 0;
        for (int n = 0; n < 12; n++) begin
            rd        = 8'($urandom_range(0, 255));
            rstop     = ($urandom_range(0, 4) != 0);
            stall_cfg = $urandom_range(0, 3);
            ack_delay = $urandom_range(0, 2);
            if (rstop) exp_q.push_back(rd);
            else exp_fe++;
            send(rd, rstop);
            if (!rstop) begin
                uart_rx = 1'b1;
                repeat (CPB) @(negedge clk_i);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk_i);
        end
        settle(20);
        check("rnd_count", got_q.size() - got_b, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rnd_data%0d", i), got_at(i), 32'(exp_q[i]));
        end
        check("rnd_fe", fe_cnt - fe_b, exp_fe);
        check("rnd_ov", ov_cnt - ov_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
